dcache_writeback_buffer: RTL and testbench
==========================================

// Module: dcache_writeback_buffer
// PURPOSE
//  Sits directly downstream of dcache: captures dirty lines ejected on write (ejected_valid/addr/data),
//  queues them in a small FIFO and drains them to the memory write port with a valid/ready handshake.
//  Provides a CAM lookup so the miss path can detect a line still pending write-back (no stale refill).
//  Coalesces a newer ejection of an already-queued line into its existing slot.
// PARAMETERS
//  line_addr_width  13  bit width of a line address (matches dcache line_addr_width)
//  line_width       64  bit width of a cache line; multiple of 64
//  depth            4   FIFO entries; power of two, >= 2
// PORTS
//  clk_i            in   1                single clock, rising edge
//  rst_i            in   1                reset, asynchronous, active-high
//  ejected_valid_i  in   1                push: dirty line ejected by dcache this cycle
//  ejected_addr_i   in   line_addr_width  line address of ejected line
//  ejected_i        in   line_width       ejected line data
//  full_o           out  1                all slots occupied; dcache must hold writes
//  empty_o          out  1                no slots occupied
//  count_o          out  $clog2(depth)+1  occupied slots
//  overflow_o       out  1                sticky: non-coalescing push dropped while full
//  mem_w_valid_o    out  1                head line offered to memory
//  mem_w_ready_i    in   1                memory accepts head this cycle
//  mem_w_addr_o     out  line_addr_width  head line address
//  mem_w_data_o     out  line_width       head line data
//  lookup_valid_i   in   1                miss path probes buffer
//  lookup_addr_i    in   line_addr_width  probed line address
//  lookup_hit_o     out  1                probed line pending (combinational)
//  lookup_data_o    out  line_width       pending data of hit entry (DCACHE_WB_FORWARD_EN only)
// BEHAVIOUR
//  - Reset (async): all entries invalid, rd/wr ptrs 0, count_o 0, empty_o 1, full_o 0, overflow_o 0,
//    mem_w_valid_o 0, lookup_hit_o 0; pending lines discarded even mid-handshake.
//  - Storage: circular FIFO, rd/wr ptrs of $clog2(depth) bits wrapping depth-1 -> 0; count held separately.
//  - mem_w_valid_o = !empty_o; addr/data = head slot; head stable while valid && !ready.
//  - Pop when mem_w_valid_o && mem_w_ready_i: head invalidated, rd_ptr++, count--.
//  - Push when ejected_valid_i, evaluated against state before the edge:
//    * addr matches a valid non-head entry -> overwrite that entry's data; no slot used, count unchanged;
//      accepted even when full.
//    * addr matches only the head -> new slot (head already offered, must not change).
//    * otherwise new slot at wr_ptr if count < depth; else dropped, overflow_o set next cycle.
//  - Push + pop same edge: count unchanged; a push while full is NOT rescued by a same-cycle pop
//    (full_o decision uses pre-edge count).
//  - Latency: push at edge N into empty buffer -> mem_w_valid_o high after edge N.
//  - full_o/empty_o/count_o registered-state derived, no combinational path from inputs.
//  - Lookup: combinational over pre-edge state; hit if any valid entry matches lookup_addr_i;
//    youngest match wins; lookup_valid_i low -> lookup_hit_o 0. Same-cycle push of probed
//    address is not seen; same-cycle pop of probed head still reports hit.
// CONFIGURATION
//  DCACHE_WB_FORWARD_EN defined: lookup_data_o = data of youngest matching entry (0 on no hit);
//    miss path may refill directly from buffer.
//  Undefined: lookup_data_o tied 0; hit only signals miss path to stall until line drains.
// STRUCTURE
//  - dcache.svh: `declare_dcache_wb_entry(addr_width, line_width) packed struct {valid, tag, data}.
//  - Sub-module dcache_wb_cam: depth-way tag compare, returns one-hot match vector plus youngest
//    match index relative to rd_ptr; reused for push coalescing and lookup.
// TESTING
//  1. Reset, push A=0x010 data 0x11..11 -> next cycle mem_w_valid_o=1, addr 0x010; ready=1 -> empty_o=1.
//  2. mem_w_ready_i=0, push 0x001..0x004 -> full_o=1,count_o=4; push 0x005 -> dropped, overflow_o=1.
//  3. Full, push 0x003 data 0xFF..FF -> accepted, count_o 4; drain shows 0x003 carries 0xFF..FF.
//  4. Head 0x001 stalled, push 0x001 data 0x22.. -> count+1; drain yields old then 0x22.. data.
//  5. Queue 0x007, lookup 0x007 -> hit=1 (data forwarded with macro, 0 without); 0x008 -> hit=0.
//  6. Push and pop same edge at count 2 -> count_o stays 2; assert rst_i mid-stall -> outputs reset at once.

Source files
------------

// File: rtl/dcache_writeback_buffer_pkg.sv
// Shared defaults for the dcache write-back buffer and its tag CAM.
package dcache_writeback_buffer_pkg;
    localparam int DEF_LINE_ADDR_WIDTH = 13;
    localparam int DEF_LINE_WIDTH      = 64;
    localparam int DEF_DEPTH           = 4;
endpackage

// File: rtl/dcache_writeback_buffer_cam.sv
// Depth-way tag CAM: one-hot match vector plus the youngest matching slot,
// where age is measured as distance from the FIFO read pointer.
module dcache_wb_cam
    import dcache_writeback_buffer_pkg::*;
#(
    parameter int addr_width = DEF_LINE_ADDR_WIDTH,
    parameter int depth      = DEF_DEPTH,
    localparam int PW        = $clog2(depth)
) (
    input  logic [depth-1:0]                 valid_i,
    input  logic [depth-1:0][addr_width-1:0] tag_i,
    input  logic [PW-1:0]                    rd_ptr_i,
    input  logic [addr_width-1:0]            addr_i,
    output logic [depth-1:0]                 match_o,
    output logic                             hit_o,
    output logic [PW-1:0]                    youngest_o
);
    genvar gi;
    generate
        for (gi = 0; gi < depth; gi++) begin : g_cmp
            assign match_o[gi] = valid_i[gi] && (tag_i[gi] == addr_i);
        end
    endgenerate

    assign hit_o = |match_o;

    logic [PW-1:0] idx;

    // Walk from head towards tail so the last match seen is the youngest.
    always_comb begin
        youngest_o = '0;
        idx        = '0;
        for (int k = 0; k < depth; k++) begin
            idx = rd_ptr_i + PW'(k);
            if (match_o[idx]) begin
                youngest_o = idx;
            end
        end
    end
endmodule

// File: rtl/dcache_writeback_buffer.sv
// Write-back FIFO behind the dcache with coalescing pushes and a miss-path CAM lookup.
// Optional macro DCACHE_WB_FORWARD_EN: lookup_data_o returns the youngest matching line.
module dcache_writeback_buffer
    import dcache_writeback_buffer_pkg::*;
#(
    parameter int line_addr_width = DEF_LINE_ADDR_WIDTH,
    parameter int line_width      = DEF_LINE_WIDTH,
    parameter int depth           = DEF_DEPTH,
    localparam int PW             = $clog2(depth),
    localparam int CW             = $clog2(depth) + 1
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       ejected_valid_i,
    input  logic [line_addr_width-1:0] ejected_addr_i,
    input  logic [line_width-1:0]      ejected_i,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [CW-1:0]              count_o,
    output logic                       overflow_o,
    output logic                       mem_w_valid_o,
    input  logic                       mem_w_ready_i,
    output logic [line_addr_width-1:0] mem_w_addr_o,
    output logic [line_width-1:0]      mem_w_data_o,
    input  logic                       lookup_valid_i,
    input  logic [line_addr_width-1:0] lookup_addr_i,
    output logic                       lookup_hit_o,
    output logic [line_width-1:0]      lookup_data_o
);
    logic [depth-1:0]                      valid_q, valid_d;
    logic [depth-1:0][line_addr_width-1:0] tag_q;
    logic [line_width-1:0]                 data_q [depth];
    logic [PW-1:0]                         rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]                         count_q, count_d;
    logic                                  overflow_q, overflow_d;

    logic [depth-1:0] head_onehot, coal_mask, coal_match, lk_match;
    logic             coal_hit, lk_hit;
    logic [PW-1:0]    coal_idx, lk_idx;
    logic             pop, push_new, coalesce;

    genvar gi;
    generate
        for (gi = 0; gi < depth; gi++) begin : g_head
            assign head_onehot[gi] = (rd_ptr_q == PW'(gi));
        end
    endgenerate

    // The head is already offered to memory, so it must never be rewritten.
    assign coal_mask = valid_q & ~head_onehot;

    dcache_wb_cam #(.addr_width(line_addr_width), .depth(depth)) u_push_cam (
        .valid_i    (coal_mask),
        .tag_i      (tag_q),
        .rd_ptr_i   (rd_ptr_q),
        .addr_i     (ejected_addr_i),
        .match_o    (coal_match),
        .hit_o      (coal_hit),
        .youngest_o (coal_idx)
    );

    dcache_wb_cam #(.addr_width(line_addr_width), .depth(depth)) u_lookup_cam (
        .valid_i    (valid_q),
        .tag_i      (tag_q),
        .rd_ptr_i   (rd_ptr_q),
        .addr_i     (lookup_addr_i),
        .match_o    (lk_match),
        .hit_o      (lk_hit),
        .youngest_o (lk_idx)
    );

    assign empty_o       = (count_q == '0);
    assign full_o        = (count_q == CW'(depth));
    assign count_o       = count_q;
    assign overflow_o    = overflow_q;
    assign mem_w_valid_o = !empty_o;
    assign mem_w_addr_o  = tag_q[rd_ptr_q];
    assign mem_w_data_o  = data_q[rd_ptr_q];

    assign pop      = mem_w_valid_o && mem_w_ready_i;
    assign coalesce = ejected_valid_i && coal_hit;
    // A same-cycle pop does not free room: fullness is judged on pre-edge count.
    assign push_new = ejected_valid_i && !coal_hit && !full_o;

    always_comb begin
        valid_d    = valid_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        overflow_d = overflow_q || (ejected_valid_i && !coal_hit && full_o);
        count_d    = count_q + CW'(push_new) - CW'(pop);
        if (pop) begin
            valid_d[rd_ptr_q] = 1'b0;
            rd_ptr_d          = rd_ptr_q + PW'(1);
        end
        if (push_new) begin
            valid_d[wr_ptr_q] = 1'b1;
            wr_ptr_d          = wr_ptr_q + PW'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_q    <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            valid_q    <= valid_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // Payload storage carries no reset; the valid bits qualify it.
    always_ff @(posedge clk_i) begin
        if (push_new) begin
            tag_q[wr_ptr_q]  <= ejected_addr_i;
            data_q[wr_ptr_q] <= ejected_i;
        end
        if (coalesce) begin
            data_q[coal_idx] <= ejected_i;
        end
    end

    assign lookup_hit_o = lookup_valid_i && lk_hit;

`ifdef DCACHE_WB_FORWARD_EN
    assign lookup_data_o = lookup_hit_o ? data_q[lk_idx] : '0;
    logic match_unused;
    assign match_unused = ^{coal_match, lk_match};
`else
    assign lookup_data_o = '0;
    logic match_unused;
    assign match_unused = ^{coal_match, lk_match, lk_idx};
`endif
endmodule

// File: tb/tb_dcache_writeback_buffer.sv
// Directed self-checking bench for dcache_writeback_buffer (default parameters).
module tb_dcache_writeback_buffer;
    localparam int AW = 13;
    localparam int LW = 64;

    logic          clk;
    logic          rst;
    logic          ej_valid;
    logic [AW-1:0] ej_addr;
    logic [LW-1:0] ej_data;
    logic          full, empty, overflow, mw_valid, mw_ready;
    logic [2:0]    count;
    logic [AW-1:0] mw_addr;
    logic [LW-1:0] mw_data;
    logic          lk_valid;
    logic [AW-1:0] lk_addr;
    logic          lk_hit;
    logic [LW-1:0] lk_data;

    int n_checks = 0;
    int n_fail   = 0;

    dcache_writeback_buffer dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .ejected_valid_i (ej_valid),
        .ejected_addr_i  (ej_addr),
        .ejected_i       (ej_data),
        .full_o          (full),
        .empty_o         (empty),
        .count_o         (count),
        .overflow_o      (overflow),
        .mem_w_valid_o   (mw_valid),
        .mem_w_ready_i   (mw_ready),
        .mem_w_addr_o    (mw_addr),
        .mem_w_data_o    (mw_data),
        .lookup_valid_i  (lk_valid),
        .lookup_addr_i   (lk_addr),
        .lookup_hit_o    (lk_hit),
        .lookup_data_o   (lk_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [AW-1:0] a, input logic [LW-1:0] d);
        ej_valid = 1'b1; ej_addr = a; ej_data = d;
        tick();
        ej_valid = 1'b0;
        $display("push addr=%03h data=%016h count=%0d", a, d, count);
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        #2;
        rst = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b0; #2; rst = 1'b1; #2;
        lk_valid = 1'b1; lk_addr = '0;
        #1;
        n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty: got %0b want 1", empty); end
        n_checks++; if (full !== 1'b0) begin n_fail++; $display("FAIL reset_full: got %0b want 0", full); end
        n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", count); end
        n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow: got %0b want 0", overflow); end
        n_checks++; if (mw_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %0b want 0", mw_valid); end
        n_checks++; if (lk_hit !== 1'b0) begin n_fail++; $display("FAIL reset_hit: got %0b want 0", lk_hit); end
        lk_valid = 1'b0;
        tick(); tick();
        rst = 1'b0;
        tick();
        $display("reset done");
    endtask

    task automatic test_basic();
        push(13'h010, {8{8'h11}});
        n_checks++; if (mw_valid !== 1'b1) begin n_fail++; $display("FAIL basic_valid: got %0b want 1", mw_valid); end
        n_checks++; if (mw_addr !== 13'h010) begin n_fail++; $display("FAIL basic_addr: got %03h want 010", mw_addr); end
        n_checks++; if (mw_data !== {8{8'h11}}) begin n_fail++; $display("FAIL basic_data: got %016h want %016h", mw_data, {8{8'h11}}); end
        mw_ready = 1'b1;
        tick();
        mw_ready = 1'b0;
        n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL basic_empty: got %0b want 1", empty); end
        n_checks++; if (mw_valid !== 1'b0) begin n_fail++; $display("FAIL basic_drained: got %0b want 0", mw_valid); end
        $display("basic: drained addr 010");
    endtask

    task automatic test_full_overflow();
        logic [3:0] n;
        for (int i = 1; i <= 4; i++) begin
            n = 4'(i);
            push(13'(i), {16{n}});
        end
        n_checks++; if (full !== 1'b1) begin n_fail++; $display("FAIL full_flag: got %0b want 1", full); end
        n_checks++; if (count !== 3'd4) begin n_fail++; $display("FAIL full_count: got %0d want 4", count); end
        n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL full_no_ovf: got %0b want 0", overflow); end
        push(13'h005, {16{4'h5}});
        n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL drop_overflow: got %0b want 1", overflow); end
        n_checks++; if (count !== 3'd4) begin n_fail++; $display("FAIL drop_count: got %0d want 4", count); end
    endtask

    task automatic test_coalesce_full();
        logic [3:0]    n;
        logic [LW-1:0] exp_d;
        push(13'h003, {LW{1'b1}});
        n_checks++; if (count !== 3'd4) begin n_fail++; $display("FAIL coal_count: got %0d want 4", count); end
        mw_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            n = 4'(i);
            exp_d = (i == 3) ? {LW{1'b1}} : {16{n}};
            n_checks++; if (mw_addr !== 13'(i)) begin n_fail++; $display("FAIL coal_drain_addr: got %03h want %03h", mw_addr, 13'(i)); end
            n_checks++; if (mw_data !== exp_d) begin n_fail++; $display("FAIL coal_drain_data: got %016h want %016h", mw_data, exp_d); end
            $display("drain addr=%03h data=%016h", mw_addr, mw_data);
            tick();
        end
        mw_ready = 1'b0;
        n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL coal_empty: got %0b want 1", empty); end
    endtask

    task automatic test_head_match();
        logic [LW-1:0] exp_fwd;
        pulse_reset();
        push(13'h001, {8{8'h33}});
        push(13'h001, {8{8'h22}});
        n_checks++; if (count !== 3'd2) begin n_fail++; $display("FAIL head_count: got %0d want 2", count); end
        lk_valid = 1'b1; lk_addr = 13'h001;
        #1;
`ifdef DCACHE_WB_FORWARD_EN
        exp_fwd = {8{8'h22}};
`else
        exp_fwd = '0;
`endif
        n_checks++; if (lk_hit !== 1'b1) begin n_fail++; $display("FAIL head_lk_hit: got %0b want 1", lk_hit); end
        n_checks++; if (lk_data !== exp_fwd) begin n_fail++; $display("FAIL head_lk_young: got %016h want %016h", lk_data, exp_fwd); end
        lk_valid = 1'b0;
        mw_ready = 1'b1;
        n_checks++; if (mw_data !== {8{8'h33}}) begin n_fail++; $display("FAIL head_old_data: got %016h want %016h", mw_data, {8{8'h33}}); end
        tick();
        n_checks++; if (mw_addr !== 13'h001) begin n_fail++; $display("FAIL head_new_addr: got %03h want 001", mw_addr); end
        n_checks++; if (mw_data !== {8{8'h22}}) begin n_fail++; $display("FAIL head_new_data: got %016h want %016h", mw_data, {8{8'h22}}); end
        tick();
        mw_ready = 1'b0;
        n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL head_empty: got %0b want 1", empty); end
    endtask

    task automatic test_lookup();
        logic [LW-1:0] exp_fwd;
        push(13'h007, {8{8'h77}});
`ifdef DCACHE_WB_FORWARD_EN
        exp_fwd = {8{8'h77}};
`else
        exp_fwd = '0;
`endif
        lk_valid = 1'b1; lk_addr = 13'h007; #1;
        n_checks++; if (lk_hit !== 1'b1) begin n_fail++; $display("FAIL lk_hit7: got %0b want 1", lk_hit); end
        n_checks++; if (lk_data !== exp_fwd) begin n_fail++; $display("FAIL lk_data7: got %016h want %016h", lk_data, exp_fwd); end
        lk_addr = 13'h008; #1;
        n_checks++; if (lk_hit !== 1'b0) begin n_fail++; $display("FAIL lk_miss8: got %0b want 0", lk_hit); end
        n_checks++; if (lk_data !== '0) begin n_fail++; $display("FAIL lk_data8: got %016h want 0", lk_data); end
        lk_valid = 1'b0; lk_addr = 13'h007; #1;
        n_checks++; if (lk_hit !== 1'b0) begin n_fail++; $display("FAIL lk_gated: got %0b want 0", lk_hit); end
        // Same-cycle push of the probed address is invisible; same-cycle pop of probed head still hits.
        lk_valid = 1'b1; lk_addr = 13'h009; ej_valid = 1'b1; ej_addr = 13'h009; ej_data = '1; #1;
        n_checks++; if (lk_hit !== 1'b0) begin n_fail++; $display("FAIL lk_same_push: got %0b want 0", lk_hit); end
        lk_addr = 13'h007; mw_ready = 1'b1; #1;
        n_checks++; if (lk_hit !== 1'b1) begin n_fail++; $display("FAIL lk_same_pop: got %0b want 1", lk_hit); end
        tick();
        ej_valid = 1'b0; lk_valid = 1'b0;
        tick();
        mw_ready = 1'b0;
        n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL lk_empty: got %0b want 1", empty); end
        $display("lookup scenario done");
    endtask

    task automatic test_back_to_back();
        push(13'h020, {8{8'h20}});
        push(13'h021, {8{8'h21}});
        ej_valid = 1'b1; ej_addr = 13'h022; ej_data = {8{8'h22}}; mw_ready = 1'b1;
        tick();
        ej_valid = 1'b0; mw_ready = 1'b0;
        n_checks++; if (count !== 3'd2) begin n_fail++; $display("FAIL b2b_count: got %0d want 2", count); end
        n_checks++; if (mw_addr !== 13'h021) begin n_fail++; $display("FAIL b2b_head: got %03h want 021", mw_addr); end
        push(13'h030, '0);
        push(13'h031, '0);
        n_checks++; if (count !== 3'd4) begin n_fail++; $display("FAIL b2b_full: got %0d want 4", count); end
        ej_valid = 1'b1; ej_addr = 13'h040; mw_ready = 1'b1;
        tick();
        ej_valid = 1'b0; mw_ready = 1'b0;
        n_checks++; if (count !== 3'd3) begin n_fail++; $display("FAIL b2b_norescue_cnt: got %0d want 3", count); end
        n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL b2b_norescue_ovf: got %0b want 1", overflow); end
        #2;
        rst = 1'b1; #1;
        n_checks++; if (mw_valid !== 1'b0) begin n_fail++; $display("FAIL async_valid: got %0b want 0", mw_valid); end
        n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL async_empty: got %0b want 1", empty); end
        n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL async_count: got %0d want 0", count); end
        n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL async_ovf: got %0b want 0", overflow); end
        rst = 1'b0;
        tick();
        $display("back-to-back and async reset done");
    endtask

    initial begin
        rst = 1'b0; ej_valid = 1'b0; ej_addr = '0; ej_data = '0;
        mw_ready = 1'b0; lk_valid = 1'b0; lk_addr = '0;
        test_reset();
        test_basic();
        test_full_overflow();
        test_coalesce_full();
        test_head_match();
        test_lookup();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
